// File: rtl/piece_commit.sv
// piece_commit: locks a landed tetromino into board RAM, then removes full rows by shifting
// everything above them down one row at a time.
module piece_commit #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 24,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [4:0]        X_anchor,
  input  logic [5:0]        Y_anchor,
  input  logic [2:0]        block,
  input  logic [1:0]        curr_rotation,
  input  logic [DATA_W-1:0] cell_value,
  input  logic [DATA_W-1:0] ram_Q,
  output logic [7:0]        ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              complete,
  output logic [2:0]        lines_cleared
);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7:0] W8 = 8'(WIDTH);
  localparam logic [7:0] H8 = 8'(HEIGHT);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_TAIL = CW'(WIDTH);

  typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, TOPCLR, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [RW-1:0]     row_q, row_d, rr_q, rr_d;
  logic [CW-1:0]     col_q, col_d;
  logic              ph_q, ph_d, full_q, full_d;
  logic [2:0]        lines_q, lines_d;
  logic [4:0]        xa_q, xa_d;
  logic [5:0]        ya_q, ya_d;
  logic [2:0]        blk_q, blk_d;
  logic [1:0]        rot_q, rot_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [15:0]       offs;
  logic [5:0]        wx;
  logic [6:0]        wy;
  logic              row_full;

  // Returns {cy[3:0] x 2 bits, cx[3:0] x 2 bits}; cell k sits at bits [2k+1:2k] of each byte.
  // Encoding: 0=I 1=O 2=T 3=S 4=Z 5=J 6=L, 7 falls back to O.
  function automatic logic [15:0] lut(input logic [2:0] b, input logic [1:0] r);
    case ({b, r})
      5'b000_00, 5'b000_10: lut = {8'h00, 8'hE4};
      5'b000_01, 5'b000_11: lut = {8'hE4, 8'h00};
      5'b010_00:            lut = {8'h40, 8'h64};
      5'b010_01:            lut = {8'h64, 8'h15};
      5'b010_10:            lut = {8'h54, 8'h91};
      5'b010_11:            lut = {8'h64, 8'h40};
      5'b011_00, 5'b011_10: lut = {8'h50, 8'h49};
      5'b011_01, 5'b011_11: lut = {8'h94, 8'h50};
      5'b100_00, 5'b100_10: lut = {8'h50, 8'h94};
      5'b100_01, 5'b100_11: lut = {8'h94, 8'h05};
      5'b101_00:            lut = {8'h54, 8'h90};
      5'b101_01:            lut = {8'h90, 8'h04};
      5'b101_10:            lut = {8'h40, 8'hA4};
      5'b101_11:            lut = {8'hA4, 8'h45};
      5'b110_00:            lut = {8'h54, 8'h92};
      5'b110_01:            lut = {8'hA4, 8'h40};
      5'b110_10:            lut = {8'h40, 8'h24};
      5'b110_11:            lut = {8'h90, 8'h54};
      default:              lut = {8'h50, 8'h44};
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      rr_q    <= '0;
      col_q   <= '0;
      ph_q    <= 1'b0;
      full_q  <= 1'b0;
      lines_q <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      blk_q   <= '0;
      rot_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      rr_q    <= rr_d;
      col_q   <= col_d;
      ph_q    <= ph_d;
      full_q  <= full_d;
      lines_q <= lines_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      blk_q   <= blk_d;
      rot_q   <= rot_d;
      val_q   <= val_d;
    end

  // ram_Q of column x arrives while column x+1 is addressed, hence the 11th scan cycle
  assign row_full = full_q & |ram_Q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    rr_d    = rr_q;
    col_d   = col_q;
    ph_d    = ph_q;
    full_d  = full_q;
    lines_d = lines_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    blk_d   = blk_q;
    rot_d   = rot_q;
    val_d   = val_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = WRITE;
        k_d     = '0;
        lines_d = '0;
        xa_d    = X_anchor;
        ya_d    = Y_anchor;
        blk_d   = block;
        rot_d   = curr_rotation;
        val_d   = cell_value;
      end
      WRITE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = SCAN;
          row_d   = ROW_LAST;
          col_d   = '0;
        end
      end
      SCAN: begin
        col_d  = col_q + 1'b1;
        full_d = (col_q == '0) | row_full;
        if (col_q == COL_TAIL) begin
          col_d = '0;
          ph_d  = 1'b0;
          rr_d  = row_q;
          if (row_full) state_d = (row_q == '0) ? TOPCLR : SHIFT;
          else if (row_q == '0) state_d = DONE;
          else row_d = row_q - 1'b1;
        end
      end
      SHIFT: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          if (col_q == COL_LAST) begin
            if (rr_q == RW'(1)) state_d = TOPCLR;
            else rr_d = rr_q - 1'b1;
          end
        end
      end
      TOPCLR: begin
        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        if (col_q == COL_LAST) begin
          state_d = SCAN;
          lines_d = (lines_q == 3'd4) ? lines_q : lines_q + 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    offs     = lut(blk_q, rot_q);
    wx       = 6'(xa_q) + 6'(offs[{1'b0, k_q, 1'b0} +: 2]);
    wy       = 7'(ya_q) + 7'(offs[{1'b1, k_q, 1'b0} +: 2]);
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    busy     = state_q inside {WRITE, SCAN, SHIFT, TOPCLR};
    complete = state_q == DONE;
    case (state_q)
      WRITE: begin
        ram_addr = 8'(wy) * W8 + 8'(wx);
        ram_data = val_q;
        ram_wren = (8'(wx) < W8) && (8'(wy) < H8);
      end
      SCAN: ram_addr = 8'(row_q) * W8 + 8'(col_q);
      SHIFT: begin
        ram_addr = (ph_q ? 8'(rr_q) : 8'(rr_q) - 8'd1) * W8 + 8'(col_q);
        ram_data = ram_Q;
        ram_wren = ph_q;
      end
      TOPCLR: begin
        ram_addr = 8'(col_q);
        ram_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign lines_cleared = lines_q;
endmodule

// File: tb/tb_piece_commit.sv
// tb_piece_commit: random and directed commits against a row-level board model.
module tb_piece_commit;
  localparam int W = 10, H = 24, DW = 6;

  logic          clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [4:0]    X_anchor = '0;
  logic [5:0]    Y_anchor = '0;
  logic [2:0]    block = '0;
  logic [1:0]    curr_rotation = '0;
  logic [DW-1:0] cell_value = '0, ram_Q, ram_data;
  logic [7:0]    ram_addr;
  logic          ram_wren, busy, complete;
  logic [2:0]    lines_cleared;

  logic [DW-1:0] mem [0:255];
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  logic [DW-1:0] ref_b [0:H-1][0:W-1];
  int exp_lines, exp_lat;
  int exp_addr[$];
  int n_chk = 0, n_pass = 0;

  piece_commit dut (
    .clk(clk), .resetn(resetn), .start(start), .X_anchor(X_anchor), .Y_anchor(Y_anchor),
    .block(block), .curr_rotation(curr_rotation), .cell_value(cell_value), .ram_Q(ram_Q),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .busy(busy),
    .complete(complete), .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wren) mem[ram_addr] <= ram_data;
    ram_Q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // I: even rotation horizontal, odd vertical; O: 2x2; T (rotation 0): flat bar with a nub below
  function automatic void cell_of(input int b, input int r, input int k, output int cx, output int cy);
    if (b == 1) begin cx = k % 2; cy = k / 2; end
    else if (b == 2) begin cx = (k == 3) ? 1 : k; cy = (k == 3) ? 1 : 0; end
    else if (r % 2 == 1) begin cx = 0; cy = k; end
    else begin cx = k; cy = 0; end
  endfunction

  task automatic model(input int x, input int y, input int b, input int r, input int v);
    int cx, cy, row;
    bit full;
    exp_addr.delete();
    for (int k = 0; k < 4; k++) begin
      cell_of(b, r, k, cx, cy);
      if (x + cx < W && y + cy < H) begin
        ref_b[y+cy][x+cx] = DW'(v);
        exp_addr.push_back((y + cy) * W + x + cx);
      end
    end
    exp_lines = 0;
    exp_lat = 5;
    row = H - 1;
    while (row >= 0) begin
      exp_lat += W + 1;
      full = 1'b1;
      for (int c = 0; c < W; c++) if (ref_b[row][c] == 0) full = 1'b0;
      if (full) begin
        exp_lat += 2 * W * row + W;
        for (int j = row; j > 0; j--) for (int c = 0; c < W; c++) ref_b[j][c] = ref_b[j-1][c];
        for (int c = 0; c < W; c++) ref_b[0][c] = '0;
        if (exp_lines < 4) exp_lines++;
      end else row--;
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) ref_b[r][c] = '0;
  endtask

  task automatic gen_board(input int pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        ref_b[r][c] = ($urandom_range(0, 99) < pct) ? DW'($urandom_range(1, 63)) : '0;
  endtask

  task automatic setup_quad();
    clear_board();
    for (int r = 20; r < H; r++) for (int c = 0; c < W - 1; c++) ref_b[r][c] = DW'($urandom_range(1, 63));
  endtask

  task automatic preload();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_addr = 8'(a);
      pl_data = (a < W * H) ? ref_b[a/W][a%W] : '0;
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_board(input string tag);
    logic [63:0] g, e;
    for (int r = 0; r < H; r++) begin
      g = '0;
      e = '0;
      for (int c = 0; c < W; c++) begin
        g[c*DW +: DW] = mem[r*W+c];
        e[c*DW +: DW] = ref_b[r][c];
      end
      chk($sformatf("%s_row%0d", tag, r), g, e);
    end
  endtask

  task automatic commit(input int x, input int y, input int b, input int r, input int v,
                        input bit dup, input string tag);
    int cyc;
    int wa[$];
    model(x, y, b, r, v);
    @(negedge clk);
    start = 1'b1;
    X_anchor = 5'(x);
    Y_anchor = 6'(y);
    block = 3'(b);
    curr_rotation = 2'(r);
    cell_value = DW'(v);
    @(negedge clk);
    start = 1'b0;
    X_anchor = 5'($urandom);
    Y_anchor = 6'($urandom);
    block = 3'($urandom);
    curr_rotation = 2'($urandom);
    cell_value = DW'($urandom);
    cyc = 1;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    while (!complete && cyc < 20000) begin
      if (cyc <= 4 && ram_wren) wa.push_back(int'(ram_addr));
      if (dup && cyc == 3) begin
        start = 1'b1;
        X_anchor = 5'd0;
        Y_anchor = 6'd0;
        block = 3'd1;
        cell_value = DW'(7);
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_complete"}, 64'(complete), 64'(1));
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy_done"}, 64'(busy), 64'(0));
    chk({tag, "_lines"}, 64'(lines_cleared), 64'(exp_lines));
    chk({tag, "_wcount"}, 64'(wa.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++)
      chk($sformatf("%s_waddr%0d", tag, i), 64'(i < wa.size() ? wa[i] : -1), 64'(exp_addr[i]));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(complete), 64'(0));
    chk({tag, "_hold"}, 64'(lines_cleared), 64'(exp_lines));
    check_board(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_complete", 64'(complete), 64'(0));
    chk("rst_wren", 64'(ram_wren), 64'(0));
    chk("rst_lines", 64'(lines_cleared), 64'(0));
    resetn = 1'b1;

    clear_board();
    preload();
    commit(4, 22, 1, 0, 5, 1'b0, "o_piece");
    chk("o_latency_const", 64'(exp_lat), 64'(4 + 24 * 11 + 1));

    clear_board();
    for (int c = 0; c < 8; c++) ref_b[H-1][c] = DW'($urandom_range(1, 63));
    preload();
    commit(8, 20, 0, 1, 9, 1'b0, "i_col8");
    commit(9, 20, 0, 3, 10, 1'b0, "i_col9");

    setup_quad();
    preload();
    commit(9, 20, 0, 1, 12, 1'b0, "quad");

    gen_board(40);
    preload();
    commit(2, 5, 1, 2, 33, 1'b1, "dup");

    clear_board();
    preload();
    commit(8, 5, 2, 0, 17, 1'b0, "edge_t");
    commit(9, 10, 0, 0, 21, 1'b0, "edge_i");

    setup_quad();
    preload();
    @(negedge clk);
    start = 1'b1;
    X_anchor = 5'd9;
    Y_anchor = 6'd20;
    block = 3'd0;
    curr_rotation = 2'd1;
    cell_value = DW'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (520) @(negedge clk);
    chk("mid_lines", 64'(lines_cleared), 64'(1));
    chk("mid_busy", 64'(busy), 64'(1));
    resetn = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_wren", 64'(ram_wren), 64'(0));
    chk("abort_complete", 64'(complete), 64'(0));
    chk("abort_lines", 64'(lines_cleared), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    setup_quad();
    preload();
    commit(9, 20, 0, 1, 44, 1'b0, "after_rst");

    for (int t = 0; t < 8; t++) begin
      int b, r;
      gen_board(85);
      preload();
      b = $urandom_range(0, 2);
      r = (b == 2) ? 0 : $urandom_range(0, 3);
      commit($urandom_range(0, 9), $urandom_range(0, 21), b, r, $urandom_range(1, 63), 1'b0,
             $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
